// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   localparam int DIV_CYCLES_DEFAULT = 33;
   localparam int REG_IDX_W          = 5;
   localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MDU_WAIT   = 2'd2
   } ctrl_state_e;

   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   function automatic logic load_use_hit(
      input logic                 ex_memread,
      input logic [REG_IDX_W-1:0] ex_rd,
      input logic [REG_IDX_W-1:0] id_rs1,
      input logic [REG_IDX_W-1:0] id_rs2,
      input logic                 id_uses_rs1,
      input logic                 id_uses_rs2
   );
      return ex_memread && (ex_rd != REG_X0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
              (id_uses_rs2 && (id_rs2 == ex_rd)));
   endfunction

endpackage

// File: rtl/mdu_stall_counter.sv
// Down-counter tracking the remaining stall cycles of a multi-cycle divide.
module mdu_stall_counter #(
   parameter int W = 6
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Neither load nor dec asserted means hold, which is how memory freezes pause the divide.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Define MDU_MULTICYCLE_EN to enable multi-cycle divide occupancy of EX.
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 BUSYWAIT,
   input  logic [REG_IDX_W-1:0] ID_RS1,
   input  logic [REG_IDX_W-1:0] ID_RS2,
   input  logic                 ID_USES_RS1,
   input  logic                 ID_USES_RS2,
   input  logic [REG_IDX_W-1:0] EX_RD,
   input  logic                 EX_MEMREAD,
   input  logic                 EX_REDIRECT,
   input  logic                 EX_MDU_DIV,
   output logic                 PC_WRITE,
   output logic                 IF_ID_WRITE,
   output logic                 ID_EX_WRITE,
   output logic                 EX_MEM_WRITE,
   output logic                 IF_ID_FLUSH,
   output logic                 ID_EX_FLUSH,
   output logic                 EX_MEM_FLUSH,
   output logic                 MDU_BUSY
);

   ctrl_state_e state_q;
   ctrl_state_e state_d;
   logic        load_use;

   assign load_use = load_use_hit(EX_MEMREAD, EX_RD, ID_RS1, ID_RS2,
                                  ID_USES_RS1, ID_USES_RS2);

`ifdef MDU_MULTICYCLE_EN
   localparam int                CNT_W    = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;

   mdu_stall_counter #(
      .W(CNT_W)
   ) u_cnt (
      .CLK      (CLK),
      .RESET    (RESET),
      .load     (cnt_load),
      .load_val (CNT_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );
`else
   logic unused_div;
   assign unused_div = ^{EX_MDU_DIV, (DIV_CYCLES > 1)};
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      PC_WRITE     = 1'b1;
      IF_ID_WRITE  = 1'b1;
      ID_EX_WRITE  = 1'b1;
      EX_MEM_WRITE = 1'b1;
      IF_ID_FLUSH  = 1'b0;
      ID_EX_FLUSH  = 1'b0;
      EX_MEM_FLUSH = 1'b0;
      MDU_BUSY     = 1'b0;
`ifdef MDU_MULTICYCLE_EN
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
`endif
      if (RESET) begin
         PC_WRITE     = 1'b0;
         IF_ID_WRITE  = 1'b0;
         ID_EX_WRITE  = 1'b0;
         EX_MEM_WRITE = 1'b0;
      end else if (BUSYWAIT) begin
         // Freeze everything; state and counter hold so the stall resumes exactly.
         PC_WRITE     = 1'b0;
         IF_ID_WRITE  = 1'b0;
         ID_EX_WRITE  = 1'b0;
         EX_MEM_WRITE = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (EX_REDIRECT) begin
                  IF_ID_FLUSH = 1'b1;
                  ID_EX_FLUSH = 1'b1;
`ifdef MDU_MULTICYCLE_EN
               end else if (EX_MDU_DIV) begin
                  PC_WRITE     = 1'b0;
                  IF_ID_WRITE  = 1'b0;
                  ID_EX_WRITE  = 1'b0;
                  EX_MEM_FLUSH = 1'b1;
                  MDU_BUSY     = 1'b1;
                  cnt_load     = 1'b1;
                  state_d      = MDU_WAIT;
`endif
               end else if (load_use) begin
                  PC_WRITE    = 1'b0;
                  IF_ID_WRITE = 1'b0;
                  ID_EX_FLUSH = 1'b1;
                  state_d     = LOAD_STALL;
               end
            end
            LOAD_STALL: begin
               state_d = RUN;
            end
`ifdef MDU_MULTICYCLE_EN
            MDU_WAIT: begin
               MDU_BUSY = 1'b1;
               if (!cnt_zero) begin
                  PC_WRITE     = 1'b0;
                  IF_ID_WRITE  = 1'b0;
                  ID_EX_WRITE  = 1'b0;
                  EX_MEM_FLUSH = 1'b1;
                  cnt_dec      = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
`endif
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

   localparam int DIV_CYCLES = 4;
`ifdef MDU_MULTICYCLE_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif

   // Output vector: {PC_W, IF_ID_W, ID_EX_W, EX_MEM_W, IF_ID_F, ID_EX_F, EX_MEM_F, MDU_BUSY}
   localparam logic [7:0] O_ZERO  = 8'b0000_0000;
   localparam logic [7:0] O_DEF   = 8'b1111_0000;
   localparam logic [7:0] O_REDIR = 8'b1111_1100;
   localparam logic [7:0] O_LU    = 8'b0011_0100;
   localparam logic [7:0] O_DIV   = 8'b0001_0011;
   localparam logic [7:0] O_REL   = 8'b1111_0001;

   logic       CLK;
   logic       RESET;
   logic       BUSYWAIT;
   logic [4:0] ID_RS1;
   logic [4:0] ID_RS2;
   logic       ID_USES_RS1;
   logic       ID_USES_RS2;
   logic [4:0] EX_RD;
   logic       EX_MEMREAD;
   logic       EX_REDIRECT;
   logic       EX_MDU_DIV;
   logic       PC_WRITE;
   logic       IF_ID_WRITE;
   logic       ID_EX_WRITE;
   logic       EX_MEM_WRITE;
   logic       IF_ID_FLUSH;
   logic       ID_EX_FLUSH;
   logic       EX_MEM_FLUSH;
   logic       MDU_BUSY;
   logic [7:0] outs;

   int errors = 0;
   int checks = 0;

   // Reference model: remaining EX cycles of a divide, and whether a load-use bubble was just inserted.
   int m_div_left = 0;
   bit m_bubble   = 0;

   assign outs = {PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
                  IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MDU_BUSY};

   pipeline_hazard_ctrl #(
      .DIV_CYCLES(DIV_CYCLES)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .BUSYWAIT     (BUSYWAIT),
      .ID_RS1       (ID_RS1),
      .ID_RS2       (ID_RS2),
      .ID_USES_RS1  (ID_USES_RS1),
      .ID_USES_RS2  (ID_USES_RS2),
      .EX_RD        (EX_RD),
      .EX_MEMREAD   (EX_MEMREAD),
      .EX_REDIRECT  (EX_REDIRECT),
      .EX_MDU_DIV   (EX_MDU_DIV),
      .PC_WRITE     (PC_WRITE),
      .IF_ID_WRITE  (IF_ID_WRITE),
      .ID_EX_WRITE  (ID_EX_WRITE),
      .EX_MEM_WRITE (EX_MEM_WRITE),
      .IF_ID_FLUSH  (IF_ID_FLUSH),
      .ID_EX_FLUSH  (ID_EX_FLUSH),
      .EX_MEM_FLUSH (EX_MEM_FLUSH),
      .MDU_BUSY     (MDU_BUSY)
   );

   // ---------------- clock ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- model ----------------
   function automatic bit model_lu();
      return EX_MEMREAD && (EX_RD != 5'd0) &&
             ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
   endfunction

   function automatic logic [7:0] model_out();
      if (RESET)                   return O_ZERO;
      if (BUSYWAIT)                return O_ZERO;
      if (m_div_left > 1)          return O_DIV;
      if (m_div_left == 1)         return O_REL;
      if (m_bubble)                return O_DEF;
      if (EX_REDIRECT)             return O_REDIR;
      if (MDU_EN && EX_MDU_DIV)    return O_DIV;
      if (model_lu())              return O_LU;
      return O_DEF;
   endfunction

   task automatic model_commit();
      if (RESET) begin
         m_div_left = 0;
         m_bubble   = 0;
      end else if (BUSYWAIT) begin
      end else if (m_div_left > 1) begin
         m_div_left--;
      end else if (m_div_left == 1) begin
         m_div_left = 0;
      end else if (m_bubble) begin
         m_bubble = 0;
      end else if (EX_REDIRECT) begin
      end else if (MDU_EN && EX_MDU_DIV) begin
         m_div_left = DIV_CYCLES - 1;
      end else if (model_lu()) begin
         m_bubble = 1;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic set_in(input logic bw, input logic redir, input logic div,
                         input logic memrd, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
      BUSYWAIT    = bw;
      EX_REDIRECT = redir;
      EX_MDU_DIV  = div;
      EX_MEMREAD  = memrd;
      EX_RD       = rd;
      ID_RS1      = rs1;
      ID_RS2      = rs2;
      ID_USES_RS1 = u1;
      ID_USES_RS2 = u2;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_commit();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge CLK);
      #1;
      checks++;
      if (outs !== O_ZERO) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", outs, O_ZERO);
      end
      tick();
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checks++;
      if (outs !== O_DEF) begin
         errors++;
         $display("FAIL reset_release_default: got %b expected %b", outs, O_DEF);
      end
      tick();
   endtask

   task automatic test_load_use();
      logic [7:0] exp_seq [3];
      exp_seq = '{O_LU, O_DEF, O_LU};
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         set_in(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
         #1;
         checks++;
         if (outs !== exp_seq[c]) begin
            errors++;
            $display("FAIL load_use_c%0d: got %b expected %b", c, outs, exp_seq[c]);
         end
         tick();
      end
      @(negedge CLK);
      set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      #1;
      checks++;
      if (outs !== O_DEF) begin
         errors++;
         $display("FAIL load_use_exit: got %b expected %b", outs, O_DEF);
      end
      tick();
   endtask

   task automatic test_x0_blocked();
      @(negedge CLK);
      set_in(0, 0, 0, 1, 5'd0, 5'd0, 5'd9, 1, 0);
      #1;
      checks++;
      if (outs !== O_DEF) begin
         errors++;
         $display("FAIL x0_no_stall: got %b expected %b", outs, O_DEF);
      end
      tick();
      @(negedge CLK);
      set_in(0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1);
      #1;
      checks++;
      if (outs !== O_DEF) begin
         errors++;
         $display("FAIL unused_rs1_no_stall: got %b expected %b", outs, O_DEF);
      end
      tick();
      @(negedge CLK);
      set_in(0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 1);
      #1;
      checks++;
      if (outs !== O_LU) begin
         errors++;
         $display("FAIL rs1_match_stall: got %b expected %b", outs, O_LU);
      end
      tick();
      @(negedge CLK);
      set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      #1;
      checks++;
      if (outs !== O_DEF) begin
         errors++;
         $display("FAIL rs1_match_bubble: got %b expected %b", outs, O_DEF);
      end
      tick();
   endtask

   task automatic test_redirect();
      logic [7:0] exp_seq [4];
      exp_seq = '{O_REDIR, O_LU, O_DEF, O_DEF};
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         if (c < 3) set_in(0, c == 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
         else       set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         #1;
         checks++;
         if (outs !== exp_seq[c]) begin
            errors++;
            $display("FAIL redirect_c%0d: got %b expected %b", c, outs, exp_seq[c]);
         end
         tick();
      end
   endtask

   task automatic test_divide();
      logic [7:0] exp_q[$];
      logic [7:0] exp;
      if (MDU_EN) begin
         for (int i = 0; i < DIV_CYCLES - 1; i++) exp_q.push_back(O_DIV);
         exp_q.push_back(O_REL);
      end else begin
         for (int i = 0; i < DIV_CYCLES; i++) exp_q.push_back(O_DEF);
      end
      exp_q.push_back(O_DEF);
      for (int c = 0; exp_q.size() > 0; c++) begin
         @(negedge CLK);
         set_in(0, 0, c < DIV_CYCLES, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL divide_c%0d: got %b expected %b", c, outs, exp);
         end
         tick();
      end
   endtask

   task automatic test_divide_busywait();
      logic [7:0] exp_q[$];
      logic [7:0] exp;
      int stalls;
      stalls = 0;
      if (MDU_EN) exp_q = '{O_DIV, O_DIV, O_ZERO, O_ZERO, O_DIV, O_REL, O_DEF};
      else        exp_q = '{O_DEF, O_DEF, O_ZERO, O_ZERO, O_DEF, O_DEF, O_DEF};
      for (int c = 0; exp_q.size() > 0; c++) begin
         @(negedge CLK);
         set_in(c == 2 || c == 3, 0, c < 6, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         #1;
         exp = exp_q.pop_front();
         if (PC_WRITE === 1'b0) stalls++;
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL divide_busywait_c%0d: got %b expected %b", c, outs, exp);
         end
         tick();
      end
      checks++;
      if (stalls != (MDU_EN ? DIV_CYCLES - 1 + 2 : 2)) begin
         errors++;
         $display("FAIL divide_busywait_stalls: got %0d expected %0d",
                  stalls, MDU_EN ? DIV_CYCLES - 1 + 2 : 2);
      end
   endtask

   task automatic test_reset_mid_divide();
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         set_in(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         #1;
         checks++;
         if (outs !== (MDU_EN ? O_DIV : O_DEF)) begin
            errors++;
            $display("FAIL pre_reset_divide_c%0d: got %b expected %b",
                     c, outs, MDU_EN ? O_DIV : O_DEF);
         end
         if (c == 2) begin
            #1;
            RESET = 1'b1;
            #1;
            checks++;
            if (outs !== O_ZERO) begin
               errors++;
               $display("FAIL async_reset_outputs: got %b expected %b", outs, O_ZERO);
            end
            model_commit();
         end
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         RESET = 1'b0;
         set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         #1;
         checks++;
         if (outs !== O_DEF) begin
            errors++;
            $display("FAIL post_reset_default_c%0d: got %b expected %b", c, outs, O_DEF);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [7:0] exp;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         RESET = ($urandom_range(0, 63) == 0);
         set_in($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
         #1;
         exp = model_out();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL random_c%0d: got %b expected %b", c, outs, exp);
         end
         tick();
      end
      @(negedge CLK);
      RESET = 1'b0;
      set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      RESET = 1'b1;
      set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      test_reset();
      test_load_use();
      test_x0_blocked();
      test_redirect();
      test_divide();
      test_divide_busywait();
      test_reset_mid_divide();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
